gc_tx_sequencer: RTL and testbench

GC_TX_SEQUENCER -- requirements
Module: gc_tx_sequencer

---
 rtl/gc_pkg.sv | 24 ++
 rtl/gc_us_timer.sv | 37 +++
 rtl/gc_tx_sequencer.sv | 150 +++++++++++++++
 tb/tb_gc_tx_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gc_pkg.sv
// gc_pkg: shared definitions for the GameCube/N64 line transmitter.
//   - gc_state_t : sequencer state encoding
//   - *_US       : bit-timing constants, in microseconds
//   - low_us_last: last microsecond index of the low phase for a data bit
package gc_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DATA_LOW  = 2'd1,
        DATA_HIGH = 2'd2,
        STOP_LOW  = 2'd3
    } gc_state_t;

    localparam int SLOT_US     = 4;
    localparam int ONE_LOW_US  = 1;
    localparam int ZERO_LOW_US = 3;
    localparam int STOP_LOW_US = 1;

    // A '1' is a short low, a '0' a long low; the slot length is the same.
    function automatic logic [1:0] low_us_last(input logic bit_val);
        return bit_val ? 2'(ONE_LOW_US - 1) : 2'(ZERO_LOW_US - 1);
    endfunction

endpackage

// File: rtl/gc_us_timer.sv
// gc_us_timer: microsecond tick generator plus position within a 4 us slot.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   restart   - synchronous restart: clears both counters
//   us_tick   - high on the last clk of each microsecond
//   us_cnt    - microsecond index inside the current slot (0..SLOT_US-1)
module gc_us_timer
    import gc_pkg::*;
#(
    parameter int CLKS_PER_US = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       restart,
    output logic       us_tick,
    output logic [1:0] us_cnt
);

    logic [7:0] tick_cnt;

    assign us_tick = (tick_cnt == 8'(CLKS_PER_US - 1));

    // us_cnt wraps to 0 exactly at the slot boundary, so every slot starts
    // from a fresh count and no error accumulates across bits.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            tick_cnt <= '0;
            us_cnt   <= '0;
        end else if (us_tick) begin
            tick_cnt <= '0;
            us_cnt   <= (us_cnt == 2'(SLOT_US - 1)) ? 2'd0 : us_cnt + 2'd1;
        end else begin
            tick_cnt <= tick_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/gc_tx_sequencer.sv
// gc_tx_sequencer: serialises byte frames onto a GC/N64 single-wire line.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   tx_data/valid/last- byte stream from the source (ready/valid handshake)
//   tx_ready          - byte accepted when tx_valid && tx_ready
//   line_out          - 0 drives the line low, 1 releases it high
//   busy              - frame in progress
//   done, underrun    - one-cycle completion pulse, underrun flag alongside
module gc_tx_sequencer
    import gc_pkg::*;
#(
    parameter int CLKS_PER_US = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       line_out,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    gc_state_t  state, state_nxt;
    logic [7:0] shreg, hold;
    logic       cur_last, hold_last, hold_full;
    logic [2:0] bit_cnt;
    logic       und_flag, done_r, und_r, ready_en;
    logic       us_tick;
    logic [1:0] us_cnt;
    logic       accept, low_end, slot_end, stop_end;

    // Counters sit at zero while idle, so the first slot starts aligned
    // with the cycle after acceptance.
    gc_us_timer #(.CLKS_PER_US(CLKS_PER_US)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (state == IDLE),
        .us_tick (us_tick),
        .us_cnt  (us_cnt)
    );

    assign accept   = tx_valid && tx_ready;
    assign low_end  = us_tick && (us_cnt == low_us_last(shreg[7]));
    assign slot_end = us_tick && (us_cnt == 2'(SLOT_US - 1));
    assign stop_end = us_tick && (us_cnt == 2'(STOP_LOW_US - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (accept)  state_nxt = DATA_LOW;
            DATA_LOW:  if (low_end) state_nxt = DATA_HIGH;
            DATA_HIGH: begin
                if (slot_end) begin
                    if (bit_cnt != 3'd0)                         state_nxt = DATA_LOW;
                    else if (!cur_last && (hold_full || accept)) state_nxt = DATA_LOW;
                    else                                         state_nxt = STOP_LOW;
                end
            end
            STOP_LOW:  if (stop_end) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Outputs. tx_ready is held off for one cycle after reset and during
    // the done cycle; mid-frame it only opens for a non-final byte with an
    // empty holding register.
    always_comb begin
        line_out = !((state == DATA_LOW) || (state == STOP_LOW));
        busy     = (state != IDLE);
        done     = done_r;
        underrun = und_r;
        tx_ready = ready_en &&
                   (((state == IDLE) && !done_r) ||
                    (((state == DATA_LOW) || (state == DATA_HIGH)) && !hold_full && !cur_last));
    end

    // Byte datapath and completion flags
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            hold      <= '0;
            cur_last  <= 1'b0;
            hold_last <= 1'b0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
            und_flag  <= 1'b0;
            done_r    <= 1'b0;
            und_r     <= 1'b0;
            ready_en  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            done_r   <= 1'b0;
            und_r    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        shreg     <= tx_data;
                        cur_last  <= tx_last;
                        bit_cnt   <= 3'd7;
                        hold_full <= 1'b0;
                        und_flag  <= 1'b0;
                    end
                end
                DATA_LOW, DATA_HIGH: begin
                    if (accept) begin
                        hold      <= tx_data;
                        hold_last <= tx_last;
                        hold_full <= 1'b1;
                    end
                    if ((state == DATA_HIGH) && slot_end) begin
                        bit_cnt <= bit_cnt - 3'd1;
                        if (bit_cnt != 3'd0) begin
                            shreg <= {shreg[6:0], 1'b0};
                        end else if (!cur_last && hold_full) begin
                            shreg     <= hold;
                            cur_last  <= hold_last;
                            hold_full <= 1'b0;
                        end else if (!cur_last && accept) begin
                            // Byte arrived on the boundary itself: bypass hold.
                            shreg     <= tx_data;
                            cur_last  <= tx_last;
                            hold_full <= 1'b0;
                        end else if (!cur_last) begin
                            und_flag <= 1'b1;
                        end
                    end
                end
                STOP_LOW: begin
                    if (stop_end) begin
                        done_r   <= 1'b1;
                        und_r    <= und_flag;
                        und_flag <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gc_tx_sequencer.sv
module tb_gc_tx_sequencer;

    localparam int CPU = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready, line_out, busy, done, underrun;

    int checks = 0;
    int errors = 0;
    int first_diff = -1;

    logic [8:0] src_q[$];                  // {last, data}
    logic       cap_line[$], cap_busy[$], cap_ready[$];
    int         acc_idx[$], done_idx[$], und_idx[$];
    logic       exp_line[$];

    gc_tx_sequencer #(.CLKS_PER_US(CPU)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .line_out (line_out),
        .busy     (busy),
        .done     (done),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    // ---- expected-waveform model ----
    task automatic push_level(input logic v, input int n);
        for (int i = 0; i < n; i++) exp_line.push_back(v);
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) begin
            if (b[k]) begin push_level(1'b0, CPU);     push_level(1'b1, 3 * CPU); end
            else      begin push_level(1'b0, 3 * CPU); push_level(1'b1, CPU);     end
        end
    endtask

    task automatic push_stop();
        push_level(1'b0, CPU);
    endtask

    function automatic int wave_diff(input int n);
        int nd = 0;
        first_diff = -1;
        while (exp_line.size() < n) exp_line.push_back(1'b1);
        for (int i = 0; i < n; i++)
            if (cap_line[i] !== exp_line[i]) begin
                nd++;
                if (first_diff < 0) first_diff = i;
            end
        return nd;
    endfunction

    // ---- source driver + monitor: sample at negedge, drive at posedge+1 ----
    task automatic drive_src();
        if (src_q.size() > 0) begin
            tx_valid = 1'b1;
            {tx_last, tx_data} = src_q[0];
        end else begin
            tx_valid = 1'b0;
        end
    endtask

    task automatic run(input int n);
        cap_line.delete(); cap_busy.delete(); cap_ready.delete();
        acc_idx.delete(); done_idx.delete(); und_idx.delete();
        drive_src();
        for (int i = 0; i < n; i++) begin
            automatic logic hs;
            @(negedge clk);
            hs = tx_valid && tx_ready;
            cap_line.push_back(line_out);
            cap_busy.push_back(busy);
            cap_ready.push_back(tx_ready);
            if (hs)       acc_idx.push_back(i);
            if (done)     done_idx.push_back(i);
            if (underrun) und_idx.push_back(i);
            @(posedge clk); #1;
            if (hs) void'(src_q.pop_front());
            drive_src();
        end
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        rst = 1'b1;
        tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (line_out !== 1'b1) begin errors++; $display("FAIL rst_line: got %b want 1", line_out); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0 || underrun !== 1'b0)
            begin errors++; $display("FAIL rst_pulses: done=%b underrun=%b want 0/0", done, underrun); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", tx_ready); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_hold: got %b want 0", tx_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_rise: got %b want 1", tx_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int nd, d0;
        src_q.delete(); src_q.push_back({1'b1, 8'h80});
        exp_line.delete(); push_level(1'b1, 1); push_byte(8'h80); push_stop();
        run(140);
        nd = wave_diff(140);
        checks++; if (nd !== 0) begin errors++; $display("FAIL single_wave: %0d samples differ, first at %0d, want 0", nd, first_diff); end
        checks++; if (acc_idx.size() != 1 || acc_idx[0] != 0)
            begin errors++; $display("FAIL single_accept: got %0d accepts, want 1 at 0", acc_idx.size()); end
        d0 = (done_idx.size() > 0) ? done_idx[0] : -1;
        checks++; if (done_idx.size() != 1 || d0 != 133)
            begin errors++; $display("FAIL single_done: got n=%0d at %0d, want 1 at 133", done_idx.size(), d0); end
        checks++; if (und_idx.size() != 0) begin errors++; $display("FAIL single_underrun: got %0d pulses, want 0", und_idx.size()); end
        checks++; if (cap_busy[1] !== 1'b1 || cap_busy[132] !== 1'b1 || cap_busy[133] !== 1'b0)
            begin errors++; $display("FAIL single_busy: got %b%b%b want 110", cap_busy[1], cap_busy[132], cap_busy[133]); end
        checks++; if (cap_ready[5] !== 1'b0 || cap_ready[133] !== 1'b0 || cap_ready[134] !== 1'b1)
            begin errors++; $display("FAIL single_ready: got %b%b%b want 001", cap_ready[5], cap_ready[133], cap_ready[134]); end
    endtask

    task automatic test_two_bytes();
        int nd, d0;
        src_q.delete(); src_q.push_back({1'b0, 8'hA5}); src_q.push_back({1'b1, 8'h3C});
        exp_line.delete(); push_level(1'b1, 1); push_byte(8'hA5); push_byte(8'h3C); push_stop();
        run(270);
        nd = wave_diff(270);
        checks++; if (nd !== 0) begin errors++; $display("FAIL two_wave: %0d samples differ, first at %0d, want 0", nd, first_diff); end
        checks++; if (acc_idx.size() != 2 || acc_idx[0] != 0 || acc_idx[1] != 1)
            begin errors++; $display("FAIL two_accept: got %0d accepts, want 2 at 0,1", acc_idx.size()); end
        d0 = (done_idx.size() > 0) ? done_idx[0] : -1;
        checks++; if (done_idx.size() != 1 || d0 != 261)
            begin errors++; $display("FAIL two_done: got n=%0d at %0d, want 1 at 261", done_idx.size(), d0); end
        checks++; if (und_idx.size() != 0) begin errors++; $display("FAIL two_underrun: got %0d pulses, want 0", und_idx.size()); end
    endtask

    task automatic test_underrun();
        int nd, d0, u0;
        src_q.delete(); src_q.push_back({1'b0, 8'h01});
        exp_line.delete(); push_level(1'b1, 1); push_byte(8'h01); push_stop();
        run(140);
        nd = wave_diff(140);
        checks++; if (nd !== 0) begin errors++; $display("FAIL under_wave: %0d samples differ, first at %0d, want 0", nd, first_diff); end
        d0 = (done_idx.size() > 0) ? done_idx[0] : -1;
        u0 = (und_idx.size() > 0) ? und_idx[0] : -1;
        checks++; if (done_idx.size() != 1 || d0 != 133)
            begin errors++; $display("FAIL under_done: got n=%0d at %0d, want 1 at 133", done_idx.size(), d0); end
        checks++; if (und_idx.size() != 1 || u0 != 133)
            begin errors++; $display("FAIL under_flag: got n=%0d at %0d, want 1 at 133", und_idx.size(), u0); end
    endtask

    task automatic test_reset_mid();
        int nd;
        src_q.delete(); src_q.push_back({1'b1, 8'hFF});
        run(67);                               // next cycle is inside bit 3's low phase
        rst = 1'b1;
        @(negedge clk);
        checks++; if (line_out !== 1'b0 || busy !== 1'b1)
            begin errors++; $display("FAIL mid_pre: line=%b busy=%b want 0/1", line_out, busy); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (line_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || tx_ready !== 1'b0)
            begin errors++; $display("FAIL mid_reset: line=%b busy=%b done=%b ready=%b want 1/0/0/0", line_out, busy, done, tx_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", tx_ready); end
        @(posedge clk); #1;
        exp_line.delete();
        run(150);
        nd = wave_diff(150);
        checks++; if (nd !== 0 || done_idx.size() != 0 || cap_busy[0] !== 1'b0)
            begin errors++; $display("FAIL mid_after: diffs=%0d dones=%0d busy=%b want 0/0/0", nd, done_idx.size(), cap_busy[0]); end
    endtask

    task automatic test_back_to_back();
        int nd, a1, d0, d1;
        src_q.delete(); src_q.push_back({1'b1, 8'hAA}); src_q.push_back({1'b1, 8'h55});
        exp_line.delete();
        push_level(1'b1, 1); push_byte(8'hAA); push_stop();
        push_level(1'b1, 2); push_byte(8'h55); push_stop();
        run(280);
        nd = wave_diff(280);
        checks++; if (nd !== 0) begin errors++; $display("FAIL b2b_wave: %0d samples differ, first at %0d, want 0", nd, first_diff); end
        a1 = (acc_idx.size() > 1) ? acc_idx[1] : -1;
        d0 = (done_idx.size() > 0) ? done_idx[0] : -1;
        d1 = (done_idx.size() > 1) ? done_idx[1] : -1;
        checks++; if (d0 != 133 || a1 != 134)
            begin errors++; $display("FAIL b2b_gap: done at %0d accept at %0d, want 133/134", d0, a1); end
        checks++; if (acc_idx.size() != 2 || done_idx.size() != 2 || d1 != 267)
            begin errors++; $display("FAIL b2b_count: accepts=%0d dones=%0d last done %0d, want 2/2/267", acc_idx.size(), done_idx.size(), d1); end
    endtask

    task automatic test_random();
        int nb, n, lowlen, last_fall;
        int wave_bad = 0, done_bad = 0, pulse_bad = 0, slot_bad = 0;
        for (int f = 0; f < 100; f++) begin
            nb = $urandom_range(1, 4);
            src_q.delete(); exp_line.delete(); push_level(1'b1, 1);
            for (int b = 0; b < nb; b++) begin
                automatic logic [7:0] d = 8'($urandom);
                src_q.push_back({(b == nb - 1), d});
                push_byte(d);
            end
            push_stop();
            n = 128 * nb + 7;
            run(n);
            if (wave_diff(n) != 0) wave_bad++;
            if (done_idx.size() != 1 || done_idx[0] != 128 * nb + 5 || und_idx.size() != 0) done_bad++;
            lowlen = 0; last_fall = -1;
            for (int i = 1; i < n; i++) begin
                if (!cap_line[i]) begin
                    if (cap_line[i-1]) begin
                        if (last_fall >= 0 && i - last_fall != 16) slot_bad++;
                        last_fall = i;
                    end
                    lowlen++;
                end else if (lowlen != 0) begin
                    if (lowlen != 4 && lowlen != 12) pulse_bad++;
                    lowlen = 0;
                end
            end
        end
        checks++; if (wave_bad != 0)  begin errors++; $display("FAIL rand_wave: %0d frames wrong, want 0", wave_bad); end
        checks++; if (done_bad != 0)  begin errors++; $display("FAIL rand_done: %0d frames wrong, want 0", done_bad); end
        checks++; if (pulse_bad != 0) begin errors++; $display("FAIL rand_pulse: %0d bad low pulses, want 0", pulse_bad); end
        checks++; if (slot_bad != 0)  begin errors++; $display("FAIL rand_slot: %0d bad slots, want 0", slot_bad); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_bytes();
        test_underrun();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
